// File: rtl/timing_decode_unit_if.sv
// T/D/I/B control interface between the timing/decode unit and the control logic.
// The control logic drives run/LDIR/CLRSC/bus; the unit returns timing and decode.
interface timing_decode_unit_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 run;
    logic                 ld_ir;
    logic                 clr_sc;
    logic [15:0]          bus_in;
    logic [7:0]           T;
    logic [7:0]           D;
    logic                 I;
    logic [7:0]           B;
    logic [15:0]          ir;
    logic [CNT_WIDTH-1:0] instr_cnt;
    logic                 sc_overrun;

    modport master (
        output run, ld_ir, clr_sc, bus_in,
        input  T, D, I, B, ir, instr_cnt, sc_overrun
    );

    modport slave (
        input  run, ld_ir, clr_sc, bus_in,
        output T, D, I, B, ir, instr_cnt, sc_overrun
    );
endinterface

// File: rtl/timing_decode_unit.sv
// Sequence counter and instruction register with one-hot timing/opcode decode,
// run/halt gating, retired-instruction counter and sticky SC-overrun flag.
module timing_decode_unit #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [15:0] IR_RESET  = 16'h0000
) (
    input logic                  clk,
    input logic                  rst_n,
    timing_decode_unit_if.slave  tdu
);
    logic [2:0]           sc_q, sc_d;
    logic [15:0]          ir_q, ir_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q  <= 3'd0;
            ir_q  <= IR_RESET;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            sc_q  <= sc_d;
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    // Halt freezes all state; clear wins over increment; LDIR is independent of CLRSC.
    always_comb begin
        sc_d  = sc_q;
        ir_d  = ir_q;
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (tdu.run) begin
            if (tdu.ld_ir) begin
                ir_d = tdu.bus_in;
            end
            if (tdu.clr_sc) begin
                sc_d  = 3'd0;
                cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                sc_d = sc_q + 3'd1;
                if (sc_q == 3'd7) begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        tdu.T          = 8'h01 << sc_q;
        tdu.D          = 8'h01 << ir_q[14:12];
        tdu.I          = ir_q[15];
        tdu.B          = {ir_q[10], ir_q[8], ir_q[6], ir_q[4],
                          ir_q[11], ir_q[9], ir_q[7], ir_q[5]};
        tdu.ir         = ir_q;
        tdu.instr_cnt  = cnt_q;
        tdu.sc_overrun = ovr_q;
    end
endmodule

// File: tb/tb_timing_decode_unit.sv
// Directed self-checking bench for timing_decode_unit (instantiated with a 4-bit
// instruction counter so the wrap case is reachable in 16 instructions).
module tb_timing_decode_unit;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    timing_decode_unit_if #(.CNT_WIDTH(CW)) tdu_bus ();

    timing_decode_unit #(
        .CNT_WIDTH (CW),
        .IR_RESET  (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tdu   (tdu_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tdu_bus.run    = 1'b0;
        tdu_bus.ld_ir  = 1'b0;
        tdu_bus.clr_sc = 1'b0;
        tdu_bus.bus_in = 16'h0000;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        tdu_bus.run = 1'b1;
    endtask

    task automatic test_reset();
        tdu_bus.run    = 1'b0;
        tdu_bus.ld_ir  = 1'b0;
        tdu_bus.clr_sc = 1'b0;
        tdu_bus.bus_in = 16'h0000;
        rst_n = 1'b0;
        #3;
        vectors++;
        if (tdu_bus.T !== 8'h01) begin
            miscompares++; $display("FAIL reset_T got %h want 01", tdu_bus.T);
        end
        vectors++;
        if (tdu_bus.D !== 8'h01 || tdu_bus.I !== 1'b0 || tdu_bus.B !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_DIB got D=%h I=%b B=%h want D=01 I=0 B=00",
                     tdu_bus.D, tdu_bus.I, tdu_bus.B);
        end
        vectors++;
        if (tdu_bus.ir !== 16'h0000 || tdu_bus.instr_cnt !== 4'd0
            || tdu_bus.sc_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got ir=%h cnt=%0d ovr=%b want 0000 0 0",
                     tdu_bus.ir, tdu_bus.instr_cnt, tdu_bus.sc_overrun);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sc_walk();
        logic [7:0] exp_t [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        tdu_bus.run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (tdu_bus.T !== exp_t[k]) begin
                miscompares++;
                $display("FAIL walk_T edge %0d got %h want %h", k + 1, tdu_bus.T, exp_t[k]);
            end
            if (k == 6) begin
                vectors++;
                if (tdu_bus.sc_overrun !== 1'b0) begin
                    miscompares++; $display("FAIL walk_ovr_early got 1 want 0");
                end
            end
        end
        vectors++;
        if (tdu_bus.sc_overrun !== 1'b1 || tdu_bus.instr_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL walk_overrun got ovr=%b cnt=%0d want ovr=1 cnt=0",
                     tdu_bus.sc_overrun, tdu_bus.instr_cnt);
        end
    endtask

    task automatic test_fetch();
        apply_reset();
        step();                          // now at T1
        tdu_bus.ld_ir  = 1'b1;
        tdu_bus.bus_in = 16'h9123;
        step();                          // now at T2
        tdu_bus.ld_ir  = 1'b0;
        vectors++;
        if (tdu_bus.T !== 8'h04 || tdu_bus.ir !== 16'h9123) begin
            miscompares++;
            $display("FAIL fetch_ir got T=%h ir=%h want T=04 ir=9123", tdu_bus.T, tdu_bus.ir);
        end
        // 0x9123 has IR[5] and IR[8] set -> B[0] and B[6]
        vectors++;
        if (tdu_bus.I !== 1'b1 || tdu_bus.D !== 8'h02 || tdu_bus.B !== 8'h41) begin
            miscompares++;
            $display("FAIL fetch_decode got I=%b D=%h B=%h want I=1 D=02 B=41",
                     tdu_bus.I, tdu_bus.D, tdu_bus.B);
        end
    endtask

    task automatic test_regref();
        apply_reset();
        step();
        tdu_bus.ld_ir  = 1'b1;
        tdu_bus.bus_in = 16'h7200;
        step();
        tdu_bus.ld_ir  = 1'b0;
        step();                          // now at T3
        vectors++;
        if (tdu_bus.T !== 8'h08 || tdu_bus.D !== 8'h80 || tdu_bus.I !== 1'b0
            || tdu_bus.B !== 8'h04) begin
            miscompares++;
            $display("FAIL regref_decode got T=%h D=%h I=%b B=%h want 08 80 0 04",
                     tdu_bus.T, tdu_bus.D, tdu_bus.I, tdu_bus.B);
        end
        tdu_bus.clr_sc = 1'b1;
        step();
        tdu_bus.clr_sc = 1'b0;
        vectors++;
        if (tdu_bus.T !== 8'h01 || tdu_bus.instr_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL regref_clear got T=%h cnt=%0d want T=01 cnt=1",
                     tdu_bus.T, tdu_bus.instr_cnt);
        end
    endtask

    task automatic test_halt();
        step();
        step();                          // now at T2 (T=04)
        tdu_bus.run    = 1'b0;
        tdu_bus.clr_sc = 1'b1;
        tdu_bus.ld_ir  = 1'b1;
        tdu_bus.bus_in = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (tdu_bus.T !== 8'h04 || tdu_bus.ir !== 16'h7200 || tdu_bus.instr_cnt !== 4'd1
                || tdu_bus.sc_overrun !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_hold edge %0d got T=%h ir=%h cnt=%0d ovr=%b want 04 7200 1 0",
                         k, tdu_bus.T, tdu_bus.ir, tdu_bus.instr_cnt, tdu_bus.sc_overrun);
            end
        end
        tdu_bus.run    = 1'b1;
        tdu_bus.clr_sc = 1'b0;
        tdu_bus.ld_ir  = 1'b0;
        step();
        vectors++;
        if (tdu_bus.T !== 8'h08) begin
            miscompares++; $display("FAIL halt_resume got T=%h want 08", tdu_bus.T);
        end
    endtask

    task automatic test_async_reset();
        step();                          // now at T4 (T=10)
        vectors++;
        if (tdu_bus.T !== 8'h10) begin
            miscompares++; $display("FAIL areset_pre got T=%h want 10", tdu_bus.T);
        end
        #2;
        rst_n = 1'b0;
        #1;                              // still well before the next edge
        vectors++;
        if (tdu_bus.T !== 8'h01 || tdu_bus.ir !== 16'h0000 || tdu_bus.sc_overrun !== 1'b0
            || tdu_bus.instr_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL areset_now got T=%h ir=%h ovr=%b cnt=%0d want 01 0000 0 0",
                     tdu_bus.T, tdu_bus.ir, tdu_bus.sc_overrun, tdu_bus.instr_cnt);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (tdu_bus.T !== 8'h02) begin
            miscompares++; $display("FAIL areset_release got T=%h want 02", tdu_bus.T);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step();
        step();
        step();                          // now at T3
        tdu_bus.ld_ir  = 1'b1;
        tdu_bus.clr_sc = 1'b1;
        tdu_bus.bus_in = 16'hA5F0;
        step();
        tdu_bus.ld_ir  = 1'b0;
        tdu_bus.clr_sc = 1'b0;
        vectors++;
        if (tdu_bus.T !== 8'h01 || tdu_bus.ir !== 16'hA5F0 || tdu_bus.instr_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL b2b_both got T=%h ir=%h cnt=%0d want 01 A5F0 1",
                     tdu_bus.T, tdu_bus.ir, tdu_bus.instr_cnt);
        end
        vectors++;
        if (tdu_bus.D !== 8'h04 || tdu_bus.I !== 1'b1 || tdu_bus.B !== 8'hF3) begin
            miscompares++;
            $display("FAIL b2b_decode got D=%h I=%b B=%h want 04 1 F3",
                     tdu_bus.D, tdu_bus.I, tdu_bus.B);
        end
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        tdu_bus.clr_sc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) begin
                vectors++;
                if (tdu_bus.instr_cnt !== 4'd15 || tdu_bus.T !== 8'h01) begin
                    miscompares++;
                    $display("FAIL wrap_15 got cnt=%0d T=%h want 15 01",
                             tdu_bus.instr_cnt, tdu_bus.T);
                end
            end
        end
        tdu_bus.clr_sc = 1'b0;
        vectors++;
        if (tdu_bus.instr_cnt !== 4'd0 || tdu_bus.sc_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_16 got cnt=%0d ovr=%b want 0 0",
                     tdu_bus.instr_cnt, tdu_bus.sc_overrun);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        test_reset();
        test_sc_walk();
        test_fetch();
        test_regref();
        test_halt();
        test_async_reset();
        test_back_to_back();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
